// File: rtl/comparator_iter.sv
// Multi-cycle magnitude comparator: walks the operands one chunk per cycle from
// the most significant chunk and stops at the first chunk that differs.
module comparator_iter #(
  parameter int nb_bits    = 32,
  parameter int chunk_bits = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [nb_bits-1:0] A_i,
  input  logic [nb_bits-1:0] B_i,
  input  logic               signed_i,
  input  logic               abort_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               greater_o,
  output logic               equal_o,
  output logic               lesser_o
);

  if (nb_bits < 2 || chunk_bits < 1 || (nb_bits % chunk_bits) != 0) begin : g_param_check
    $error("comparator_iter: nb_bits must be >= 2 and a multiple of chunk_bits");
  end

  localparam int n_chunks = nb_bits / chunk_bits;
  localparam int idx_w    = (n_chunks > 1) ? $clog2(n_chunks) : 1;

  localparam logic [idx_w-1:0]      top_idx  = idx_w'(n_chunks - 1);
  localparam logic [chunk_bits-1:0] msb_mask = chunk_bits'(1) << (chunk_bits - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [nb_bits-1:0]    a_reg;
  logic [nb_bits-1:0]    b_reg;
  logic                  sgn_reg;
  logic [idx_w-1:0]      idx;
  logic [idx_w-1:0]      idx_next;
  logic                  gt;
  logic                  eq;
  logic                  lt;
  logic                  gt_next;
  logic                  eq_next;
  logic                  lt_next;
  logic                  capture;

  logic [chunk_bits-1:0] chunk_a;
  logic [chunk_bits-1:0] chunk_b;
  logic                  chunk_gt;
  logic                  chunk_eq;

  // Flipping the sign bit of the top chunk turns a two's-complement order into
  // an unsigned one, so the same magnitude compare serves both modes.
  always_comb begin
    chunk_a = a_reg[int'(idx) * chunk_bits +: chunk_bits];
    chunk_b = b_reg[int'(idx) * chunk_bits +: chunk_bits];
    if (sgn_reg && (idx == top_idx)) begin
      chunk_a = chunk_a ^ msb_mask;
      chunk_b = chunk_b ^ msb_mask;
    end
    chunk_gt = (chunk_a > chunk_b);
    chunk_eq = (chunk_a == chunk_b);
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    gt_next    = gt;
    eq_next    = eq;
    lt_next    = lt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i) begin
          state_next = BUSY;
          idx_next   = top_idx;
          capture    = 1'b1;
        end
      end
      BUSY: begin
        if (abort_i) begin
          state_next = IDLE;
          gt_next    = 1'b0;
          eq_next    = 1'b0;
          lt_next    = 1'b0;
        end else if (!chunk_eq) begin
          state_next = DONE;
          gt_next    = chunk_gt;
          eq_next    = 1'b0;
          lt_next    = !chunk_gt;
        end else if (idx == '0) begin
          state_next = DONE;
          gt_next    = 1'b0;
          eq_next    = 1'b1;
          lt_next    = 1'b0;
        end else begin
          idx_next = idx - idx_w'(1);
        end
      end
      DONE: begin
        if (abort_i || ready_i) begin
          state_next = IDLE;
          gt_next    = 1'b0;
          eq_next    = 1'b0;
          lt_next    = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        gt_next    = 1'b0;
        eq_next    = 1'b0;
        lt_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sgn_reg <= 1'b0;
      idx     <= '0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      idx <= idx_next;
      gt  <= gt_next;
      eq  <= eq_next;
      lt  <= lt_next;
      if (capture) begin
        a_reg   <= A_i;
        b_reg   <= B_i;
        sgn_reg <= signed_i;
      end
    end
  end

  // Handshake outputs come straight from the state register.
  assign ready_o   = (state == IDLE);
  assign valid_o   = (state == DONE);
  assign greater_o = gt;
  assign equal_o   = eq;
  assign lesser_o  = lt;

endmodule

// File: tb/tb_comparator_iter.sv
// Self-checking bench for comparator_iter: four parameterisations side by side,
// checked every cycle against a transaction-level reference model.
module tb_comparator_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic [3:0]  valid_in = '0;
  logic [3:0]  sgn_in   = '0;
  logic [3:0]  abort_in = '0;
  logic [3:0]  rdy_in   = '0;
  logic [3:0]  ready_out;
  logic [3:0]  valid_out;
  logic [3:0]  gt_out;
  logic [3:0]  eq_out;
  logic [3:0]  lt_out;
  logic [63:0] a_in [4];
  logic [63:0] b_in [4];

  int total = 0;
  int bad = 0;

  int nb_of [4] = '{32, 32, 32, 64};
  int ck_of [4] = '{8, 32, 4, 16};

  comparator_iter #(.nb_bits(32), .chunk_bits(8)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in[0]), .ready_o(ready_out[0]),
    .A_i(a_in[0][31:0]), .B_i(b_in[0][31:0]), .signed_i(sgn_in[0]), .abort_i(abort_in[0]),
    .valid_o(valid_out[0]), .ready_i(rdy_in[0]), .greater_o(gt_out[0]),
    .equal_o(eq_out[0]), .lesser_o(lt_out[0]));

  comparator_iter #(.nb_bits(32), .chunk_bits(32)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in[1]), .ready_o(ready_out[1]),
    .A_i(a_in[1][31:0]), .B_i(b_in[1][31:0]), .signed_i(sgn_in[1]), .abort_i(abort_in[1]),
    .valid_o(valid_out[1]), .ready_i(rdy_in[1]), .greater_o(gt_out[1]),
    .equal_o(eq_out[1]), .lesser_o(lt_out[1]));

  comparator_iter #(.nb_bits(32), .chunk_bits(4)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in[2]), .ready_o(ready_out[2]),
    .A_i(a_in[2][31:0]), .B_i(b_in[2][31:0]), .signed_i(sgn_in[2]), .abort_i(abort_in[2]),
    .valid_o(valid_out[2]), .ready_i(rdy_in[2]), .greater_o(gt_out[2]),
    .equal_o(eq_out[2]), .lesser_o(lt_out[2]));

  comparator_iter #(.nb_bits(64), .chunk_bits(16)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in[3]), .ready_o(ready_out[3]),
    .A_i(a_in[3]), .B_i(b_in[3]), .signed_i(sgn_in[3]), .abort_i(abort_in[3]),
    .valid_o(valid_out[3]), .ready_i(rdy_in[3]), .greater_o(gt_out[3]),
    .equal_o(eq_out[3]), .lesser_o(lt_out[3]));

  // Reference result as {greater, equal, lesser} from plain integer compares.
  function automatic logic [2:0] ref_result(input int s, input logic [63:0] a,
                                            input logic [63:0] b, input logic sgn);
    int nb;
    logic [63:0] mask;
    logic [63:0] ua;
    logic [63:0] ub;
    longint sa;
    longint sb;
    nb   = nb_of[s];
    mask = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
    ua   = a & mask;
    ub   = b & mask;
    sa   = longint'(ua << (64 - nb));
    sb   = longint'(ub << (64 - nb));
    sa   = sa >>> (64 - nb);
    sb   = sb >>> (64 - nb);
    if (sgn) return (sa > sb) ? 3'b100 : ((sa == sb) ? 3'b010 : 3'b001);
    return (ua > ub) ? 3'b100 : ((ua == ub) ? 3'b010 : 3'b001);
  endfunction

  // Latency = position of the highest differing chunk counted from the top, plus one.
  function automatic int ref_latency(input int s, input logic [63:0] a, input logic [63:0] b);
    int nb;
    int n;
    int p;
    logic [63:0] d;
    nb = nb_of[s];
    n  = nb / ck_of[s];
    d  = (a ^ b) & ((nb == 64) ? '1 : ((64'd1 << nb) - 64'd1));
    if (d == '0) return n;
    p = 63;
    while (!d[p]) p--;
    return n - (p / ck_of[s]);
  endfunction

  int          ph  [4] = '{0, 0, 0, 0};
  int          cnt [4] = '{0, 0, 0, 0};
  logic [2:0]  res [4] = '{3'b000, 3'b000, 3'b000, 3'b000};

  always @(posedge clk or negedge rst_n) begin
    for (int s = 0; s < 4; s++) begin
      if (!rst_n) begin
        ph[s]  = 0;
        cnt[s] = 0;
        res[s] = 3'b000;
      end else begin
        case (ph[s])
          0: if (valid_in[s]) begin
            res[s] = ref_result(s, a_in[s], b_in[s], sgn_in[s]);
            cnt[s] = ref_latency(s, a_in[s], b_in[s]);
            ph[s]  = 1;
          end
          1: if (abort_in[s]) begin
            ph[s] = 0;
          end else begin
            cnt[s] = cnt[s] - 1;
            if (cnt[s] == 0) ph[s] = 2;
          end
          2: if (abort_in[s] || rdy_in[s]) ph[s] = 0;
          default: ph[s] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int s = 0; s < 4; s++) begin
      logic [4:0] exp_v;
      logic [4:0] act_v;
      exp_v = {ph[s] == 0, ph[s] == 2, (ph[s] == 2) ? res[s] : 3'b000};
      act_v = {ready_out[s], valid_out[s], gt_out[s], eq_out[s], lt_out[s]};
      total = total + 1;
      if (act_v !== exp_v) begin
        bad = bad + 1;
        $display("[TB] FAIL cycle_dut%0d t=%0t actual=%b required=%b (rdy,vld,gt,eq,lt)",
                 s, $time, act_v, exp_v);
      end
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint req);
    total = total + 1;
    if (act != req) begin
      bad = bad + 1;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One request; exp_res/exp_lat of 0 leave the checking to the model alone.
  task automatic applyStimulus(input int s, input logic [63:0] a, input logic [63:0] b,
                               input logic sgn, input int hold, input logic [2:0] exp_res,
                               input int exp_lat, input string name);
    int lat;
    bit seen;
    @(negedge clk);
    a_in[s] = a;
    b_in[s] = b;
    sgn_in[s] = sgn;
    valid_in[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in[s] = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (valid_out[s]) seen = 1'b1;
    end
    if (!seen) begin
      total = total + 1;
      bad = bad + 1;
      $display("[TB] FAIL %s_timeout actual=no_valid required=valid", name);
    end
    if (exp_lat > 0) checkOutput($sformatf("%s_lat", name), lat, exp_lat);
    if (exp_res != 3'b000)
      checkOutput($sformatf("%s_res", name), {gt_out[s], eq_out[s], lt_out[s]}, exp_res);
    for (int i = 0; i < hold; i++) begin
      valid_in[s] = ~valid_in[s];
      a_in[s] = {$urandom, $urandom};
      b_in[s] = {$urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      if (exp_res != 3'b000)
        checkOutput($sformatf("%s_hold%0d", name, i),
                    {ready_out[s], valid_out[s], gt_out[s], eq_out[s], lt_out[s]},
                    {2'b01, exp_res});
    end
    valid_in[s] = 1'b0;
    rdy_in[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy_in[s] = 1'b0;
    checkOutput($sformatf("%s_release", name), {ready_out[s], valid_out[s]}, 2'b10);
  endtask

  initial begin
    for (int s = 0; s < 4; s++) begin
      a_in[s] = '0;
      b_in[s] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_dut0", {ready_out[0], valid_out[0], gt_out[0], eq_out[0], lt_out[0]}, 5'b10000);
    checkOutput("reset_dut3", {ready_out[3], valid_out[3], gt_out[3], eq_out[3], lt_out[3]}, 5'b10000);
    rst_n = 1'b1;

    applyStimulus(0, 64'h8000_0000, 64'h7FFF_FFFF, 1'b0, 0, 3'b100, 1, "u_msb");
    applyStimulus(0, 64'h8000_0000, 64'h7FFF_FFFF, 1'b1, 0, 3'b001, 1, "s_msb");
    applyStimulus(0, 64'h1234_5678, 64'h1234_5678, 1'b0, 0, 3'b010, 4, "u_equal");
    applyStimulus(0, 64'h1234_5678, 64'h1234_5678, 1'b1, 0, 3'b010, 4, "s_equal");
    applyStimulus(0, 64'h0000_0001, 64'h0000_0002, 1'b0, 0, 3'b001, 4, "lsb_diff");
    applyStimulus(0, 64'hFFFF_FFFE, 64'hFFFF_FFFF, 1'b1, 3, 3'b001, 4, "s_neg_bp");

    // Abort in the second BUSY cycle of an equal compare.
    @(negedge clk);
    a_in[0] = 64'h1234_5678;
    b_in[0] = 64'h1234_5678;
    sgn_in[0] = 1'b0;
    valid_in[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    abort_in[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort_in[0] = 1'b0;
    checkOutput("abort_idle", {ready_out[0], valid_out[0]}, 2'b10);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("abort_quiet%0d", i), valid_out[0], 0);
    end
    applyStimulus(0, 64'h0000_0005, 64'h0000_0003, 1'b0, 0, 3'b100, 4, "after_abort");

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    a_in[0] = 64'h0000_0010;
    b_in[0] = 64'h0000_0010;
    valid_in[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("midbusy_reset", {ready_out[0], valid_out[0], gt_out[0], eq_out[0], lt_out[0]}, 5'b10000);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 64'h0100_0000, 64'h00FF_FFFF, 1'b0, 0, 3'b100, 1, "after_reset");

    // Other parameterisations with known latencies.
    applyStimulus(1, 64'hFFFF_FFFF, 64'h0, 1'b1, 0, 3'b001, 1, "w32_s");
    applyStimulus(1, 64'hFFFF_FFFF, 64'h0, 1'b0, 0, 3'b100, 1, "w32_u");
    applyStimulus(1, 64'hCAFE_F00D, 64'hCAFE_F00D, 1'b1, 0, 3'b010, 1, "w32_eq");
    applyStimulus(2, 64'h0000_0010, 64'h0000_0020, 1'b0, 0, 3'b001, 7, "c4_u");
    applyStimulus(2, 64'h8000_0000, 64'h0, 1'b1, 0, 3'b001, 1, "c4_s");
    applyStimulus(2, 64'h0BAD_BEEF, 64'h0BAD_BEEF, 1'b0, 0, 3'b010, 8, "c4_eq");
    applyStimulus(3, 64'h0001_0000_0000_0000, 64'h0, 1'b0, 0, 3'b100, 1, "w64_top");
    applyStimulus(3, 64'h8000_0000_0000_0000, 64'h1, 1'b1, 0, 3'b001, 1, "w64_s");
    applyStimulus(3, 64'hFFFF_FFFF_FFFF_0003, 64'hFFFF_FFFF_FFFF_0004, 1'b1, 1, 3'b001, 4, "w64_neg");

    // Random operands sharing a random-length common prefix.
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 8; k++) begin
        logic [63:0] ra;
        logic [63:0] rb;
        ra = {$urandom, $urandom};
        rb = ra ^ ({$urandom, $urandom} >> $urandom_range(0, 64));
        applyStimulus(s, ra, rb, 1'($urandom_range(0, 1)), k % 2, 3'b000, 0, "rand");
      end
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
